password_lock_ctrl: RTL and testbench
=====================================

Name: password_lock_ctrl

Overview:
Parametrised serial password controller and successor to the fixed 4-digit validator. Digits are entered one per strobe and held in an internal, field-programmable password register. A separate parameterised admin code is always accepted. A configurable failure counter drives lockdown. The block sits between the keypad debouncer/encoder and the LED/lock drivers.

Parameters:
DIGITS, 4, password length in digits (>=2)
DIGIT_W, 4, bits per digit
MAX_TRIES, 3, consecutive failed entries before lockdown (>=1)
DEFAULT_PW, 16'h4321, flattened reset password, digit 0 in LSBs (digits 1,2,3,4)
ADMIN_PW, 16'h9999, flattened admin code, same packing

Ports:
CLK  in  1  clock
RST  in  1  asynchronous active-low reset
enable  in  1  one-cycle strobe; one digit accepted per high cycle
digit  in  DIGIT_W  entered digit, sampled when enable=1
clear  in  1  abort the current entry, or relock when unlocked
program  in  1  when unlocked, enter password-programming mode
reset_lockdown  in  1  synchronous pulse that leaves lockdown
address  out  clog2(DIGITS)  index of the next digit expected
error_light  out  1  last entry failed
unlock_light  out  1  unlocked
lockdown  out  1  locked out
admin  out  1  current unlock was made with the admin code
programming  out  1  in programming mode
tries_left  out  clog2(MAX_TRIES+1)  MAX_TRIES minus failure count

Behaviour:
- Clock and reset: one clock, CLK. Reset is asynchronous and active-low on RST.
- Reset values: state=S_ENTRY, idx=0, pw=DEFAULT_PW, fail_cnt=0, user_ok=admin_ok=1. All lights, admin and programming are 0. tries_left=MAX_TRIES.
- All outputs are registered (Moore), decoded from state, idx and fail_cnt. The response to the last-digit strobe at cycle N appears at N+1.
- Priority within a cycle: reset_lockdown > clear > program > enable.
- S_ENTRY, on enable:
  - user_ok &= (digit==pw[idx]); admin_ok &= (digit==ADMIN_PW[idx]); idx++.
  - No early abort: all DIGITS digits are always consumed.
  - On the last digit (idx==DIGITS-1), outcomes are evaluated with the updated flags:
    - admin match -> S_UNLOCKED with admin=1, fail_cnt=0.
    - user match -> S_UNLOCKED with admin=0, fail_cnt=0.
    - neither -> fail_cnt++; if the new count == MAX_TRIES go to S_LOCKED, else go to S_ERROR.
  - idx and both flags are then reinitialised.
- S_ENTRY, on clear: idx=0, flags=1, fail_cnt unchanged.
- S_ERROR: error_light=1. enable is ignored. clear -> S_ENTRY.
- S_UNLOCKED: unlock_light=1. clear -> S_ENTRY with admin=0. program -> S_PROGRAM with idx=0. enable is ignored.
- S_PROGRAM: unlock_light=1, programming=1.
  - Each enable writes the digit into shadow[idx], idx++.
  - On the last digit, pw<=shadow (including that digit) and the state returns to S_UNLOCKED.
  - clear aborts without changing pw -> S_UNLOCKED.
  - The admin code itself cannot be changed.
- S_LOCKED: lockdown=1, error_light=1, tries_left=0.
  - Digits are still consumed and only admin_ok counts. Admin match -> S_UNLOCKED, admin=1, fail_cnt=0. Otherwise stay locked and reinitialise idx.
  - reset_lockdown -> S_ENTRY with fail_cnt=0, idx=0.
  - clear only reinitialises idx.
- reset_lockdown outside S_LOCKED: clears fail_cnt only, with no state change.
- Wrap-around:
  - fail_cnt saturates at MAX_TRIES.
  - idx never exceeds DIGITS-1; on the last digit it wraps to 0.
- A held enable counts one digit per cycle.
- Asserting RST mid-entry or mid-programming restores pw=DEFAULT_PW and discards the shadow.

Decomposition:
- Package password_lock_pkg:
  - state enum LockState {S_ENTRY, S_ERROR, S_UNLOCKED, S_PROGRAM, S_LOCKED}.
  - Function get_digit(flat, i) that extracts digit i from a flattened code.
- One sub-module, attempt_counter:
  - Saturating fail counter with inc/clr inputs.
  - Outputs tries_left and a limit flag.
  - Parameterised by MAX_TRIES.

Test Plan:
- After reset, enter 1,2,3,4 -> unlock_light=1 and admin=0 at the cycle after the 4th strobe; address back to 0.
- Enter 1,2,3,5 -> error_light=1, tries_left=2. Then clear and enter 1,2,3,4 -> unlock_light=1, tries_left=3.
- Three wrong entries (5,5,5,5 each, with clear between) -> lockdown=1, tries_left=0. Then enter 1,2,3,4 -> still locked. Then enter 9,9,9,9 -> unlock_light=1, admin=1, lockdown=0.
- While unlocked, pulse program and enter 7,0,7,0, then clear -> relocked. Entering 1,2,3,4 fails; entering 7,0,7,0 unlocks. Assert RST -> 1,2,3,4 unlocks again.
- In S_PROGRAM, enter 8,8 then clear -> password unchanged (1,2,3,4 still unlocks after relock).
- In lockdown, pulse reset_lockdown and clear in the same cycle -> S_ENTRY, fail_cnt=0. Entering 1,2,3 then clear, then 1,2,3,4 -> unlock.

Source files
------------

// File: rtl/password_lock_pkg.sv
// password_lock_pkg: shared state encoding and code-digit helper for the password lock
package password_lock_pkg;

    typedef enum logic [2:0] {S_ENTRY, S_ERROR, S_UNLOCKED, S_PROGRAM, S_LOCKED} LockState;

    localparam int MAX_FLAT = 256;
    localparam int MAX_W = 32;

    function automatic logic [MAX_W-1:0] get_digit(input logic [MAX_FLAT-1:0] flat, input int i, input int w);
        logic [MAX_W-1:0] mask;
        mask = (MAX_W'(1) << w) - MAX_W'(1);
        return MAX_W'(flat >> (i * w)) & mask;
    endfunction

endpackage

// File: rtl/password_lock_ctrl_attempt_counter.sv
// attempt_counter: saturating failed-entry counter reporting remaining tries
module attempt_counter #(
    parameter int MAX_TRIES = 3,
    localparam int TW = $clog2(MAX_TRIES + 1)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          inc,
    input  logic          clr,
    output logic [TW-1:0] tries_left,
    output logic          limit
);

    logic [TW-1:0] cnt;

    // count failures, saturating at MAX_TRIES; clear wins over increment
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (inc && cnt != TW'(MAX_TRIES)) cnt <= cnt + 1'b1;
    end

    assign tries_left = TW'(MAX_TRIES) - cnt;
    assign limit = cnt >= TW'(MAX_TRIES - 1);

endmodule

// File: rtl/password_lock_ctrl.sv
// password_lock_ctrl: serial password lock with admin code, reprogramming and lockdown
module password_lock_ctrl
    import password_lock_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int DIGIT_W = 4,
    parameter int MAX_TRIES = 3,
    parameter logic [DIGITS*DIGIT_W-1:0] DEFAULT_PW = 16'h4321,
    parameter logic [DIGITS*DIGIT_W-1:0] ADMIN_PW = 16'h9999,
    localparam int IW = $clog2(DIGITS),
    localparam int TW = $clog2(MAX_TRIES + 1)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               enable,
    input  logic [DIGIT_W-1:0] digit,
    input  logic               clear,
    input  logic               prog,
    input  logic               reset_lockdown,
    output logic [IW-1:0]      address,
    output logic               error_light,
    output logic               unlock_light,
    output logic               lockdown,
    output logic               admin,
    output logic               programming,
    output logic [TW-1:0]      tries_left
);

    localparam int PW = DIGITS * DIGIT_W;

    LockState state;
    logic [IW-1:0] idx;
    logic [PW-1:0] pw, shadow, shadow_nx;
    logic user_ok, admin_ok, u_ok, a_ok, last, go, win, inc, clr, limit;
    logic [DIGIT_W-1:0] pw_digit, admin_digit;
    logic [TW-1:0] cnt_left;

    // compare the incoming digit at the current position and stage the programming shadow
    always_comb begin
        pw_digit = DIGIT_W'(get_digit(MAX_FLAT'(pw), int'(idx), DIGIT_W));
        admin_digit = DIGIT_W'(get_digit(MAX_FLAT'(ADMIN_PW), int'(idx), DIGIT_W));
        u_ok = user_ok && digit == pw_digit;
        a_ok = admin_ok && digit == admin_digit;
        last = idx == IW'(DIGITS - 1);
        go = !reset_lockdown && !clear && enable && last;
        win = a_ok || (u_ok && state == S_ENTRY);
        inc = go && state == S_ENTRY && !win;
        clr = reset_lockdown || (go && (state == S_ENTRY || state == S_LOCKED) && win);
        shadow_nx = shadow;
        shadow_nx[int'(idx)*DIGIT_W +: DIGIT_W] = digit;
    end

    attempt_counter #(.MAX_TRIES(MAX_TRIES)) u_cnt (
        .CLK(CLK),
        .RST(RST),
        .inc(inc),
        .clr(clr),
        .tries_left(cnt_left),
        .limit(limit)
    );

    // main lock FSM: priority reset_lockdown > clear > prog > enable
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= S_ENTRY;
            idx <= '0;
            pw <= DEFAULT_PW;
            shadow <= DEFAULT_PW;
            user_ok <= 1'b1;
            admin_ok <= 1'b1;
            admin <= 1'b0;
        end else if (reset_lockdown) begin
            if (state == S_LOCKED) begin
                state <= S_ENTRY;
                idx <= '0;
                user_ok <= 1'b1;
                admin_ok <= 1'b1;
            end
        end else if (clear) begin
            state <= state == S_PROGRAM ? S_UNLOCKED : state == S_LOCKED ? S_LOCKED : S_ENTRY;
            admin <= state == S_PROGRAM && admin;
            idx <= '0;
            user_ok <= 1'b1;
            admin_ok <= 1'b1;
        end else if (prog && state == S_UNLOCKED) begin
            state <= S_PROGRAM;
            idx <= '0;
        end else if (enable) begin
            if (state == S_PROGRAM) begin
                shadow <= shadow_nx;
                idx <= last ? '0 : idx + 1'b1;
                if (last) begin
                    pw <= shadow_nx;
                    state <= S_UNLOCKED;
                end
            end else if (state == S_ENTRY || state == S_LOCKED) begin
                idx <= last ? '0 : idx + 1'b1;
                user_ok <= last | u_ok;
                admin_ok <= last | a_ok;
                if (last) begin
                    state <= win ? S_UNLOCKED : (state == S_LOCKED || limit) ? S_LOCKED : S_ERROR;
                    admin <= a_ok;
                end
            end
        end
    end

    assign address = idx;
    assign error_light = state == S_ERROR || state == S_LOCKED;
    assign unlock_light = state == S_UNLOCKED || state == S_PROGRAM;
    assign lockdown = state == S_LOCKED;
    assign programming = state == S_PROGRAM;
    assign tries_left = state == S_LOCKED ? '0 : cnt_left;

endmodule

// File: tb/tb_password_lock_ctrl.sv
// tb_password_lock_ctrl: directed test with a transaction-level lock model checked every cycle
module tb_password_lock_ctrl;

    localparam int DIGITS = 4;
    localparam int DIGIT_W = 4;
    localparam int MAX_TRIES = 3;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic enable = 1'b0;
    logic [DIGIT_W-1:0] digit = '0;
    logic clear = 1'b0;
    logic prog = 1'b0;
    logic reset_lockdown = 1'b0;
    logic [1:0] address;
    logic error_light, unlock_light, lockdown, admin, programming;
    logic [1:0] tries_left;

    int n_checks = 0;
    int n_fail = 0;
    bit chk = 1'b0;

    int mpw[DIGITS];
    int eq[$];
    int pq[$];
    bit m_unl, m_err, m_lock, m_adm, m_prog;
    int m_fails;

    always #5 CLK = ~CLK;

    password_lock_ctrl dut (
        .CLK(CLK),
        .RST(RST),
        .enable(enable),
        .digit(digit),
        .clear(clear),
        .prog(prog),
        .reset_lockdown(reset_lockdown),
        .address(address),
        .error_light(error_light),
        .unlock_light(unlock_light),
        .lockdown(lockdown),
        .admin(admin),
        .programming(programming),
        .tries_left(tries_left)
    );

    task automatic check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mpw = '{1, 2, 3, 4};
        eq.delete();
        pq.delete();
        m_unl = 0;
        m_err = 0;
        m_lock = 0;
        m_adm = 0;
        m_prog = 0;
        m_fails = 0;
    endtask

    task automatic model_step(bit en, int d, bit clr, bit pr, bit rl);
        bit is_adm;
        bit is_usr;
        if (rl) begin
            m_fails = 0;
            if (m_lock) begin
                m_lock = 0;
                eq.delete();
            end
        end else if (clr) begin
            if (m_prog) begin
                m_prog = 0;
                pq.delete();
            end else if (m_unl) begin
                m_unl = 0;
                m_adm = 0;
            end else begin
                m_err = 0;
            end
            eq.delete();
        end else if (pr && m_unl && !m_prog) begin
            m_prog = 1;
            pq.delete();
        end else if (en) begin
            if (m_prog) begin
                pq.push_back(d);
                if (pq.size() == DIGITS) begin
                    for (int i = 0; i < DIGITS; i++) mpw[i] = pq[i];
                    pq.delete();
                    m_prog = 0;
                end
            end else if (!m_unl && !m_err) begin
                eq.push_back(d);
                if (eq.size() == DIGITS) begin
                    is_adm = 1;
                    is_usr = !m_lock;
                    for (int i = 0; i < DIGITS; i++) begin
                        is_adm &= eq[i] == 9;
                        is_usr &= eq[i] == mpw[i];
                    end
                    if (is_adm || is_usr) begin
                        m_unl = 1;
                        m_adm = is_adm;
                        m_lock = 0;
                        m_fails = 0;
                    end else if (!m_lock) begin
                        m_fails++;
                        if (m_fails == MAX_TRIES) m_lock = 1;
                        else m_err = 1;
                    end
                    eq.delete();
                end
            end
        end
    endtask

    always @(negedge CLK) begin
        if (chk) begin
            check("address", int'(address), m_prog ? pq.size() : eq.size());
            check("error_light", int'(error_light), int'(m_err || m_lock));
            check("unlock_light", int'(unlock_light), int'(m_unl));
            check("lockdown", int'(lockdown), int'(m_lock));
            check("admin", int'(admin), int'(m_adm));
            check("programming", int'(programming), int'(m_prog));
            check("tries_left", int'(tries_left), MAX_TRIES - m_fails);
        end
    end

    task automatic cyc(bit en, int d, bit clr, bit pr, bit rl);
        @(negedge CLK);
        #1;
        enable = en;
        digit = DIGIT_W'(d);
        clear = clr;
        prog = pr;
        reset_lockdown = rl;
        model_step(en, d, clr, pr, rl);
        @(posedge CLK);
        #1;
        enable = 0;
        clear = 0;
        prog = 0;
        reset_lockdown = 0;
    endtask

    task automatic enter4(int a, int b, int c, int d);
        cyc(1, a, 0, 0, 0);
        cyc(1, b, 0, 0, 0);
        cyc(1, c, 0, 0, 0);
        cyc(1, d, 0, 0, 0);
    endtask

    task automatic do_clear();
        cyc(0, 0, 1, 0, 0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1;
        chk = 1;
        #1;
        check("rst_tries", int'(tries_left), 3);
        check("rst_unlock", int'(unlock_light), 0);
        check("rst_address", int'(address), 0);

        enter4(1, 2, 3, 4);
        check("t1_unlock", int'(unlock_light), 1);
        check("t1_admin", int'(admin), 0);
        check("t1_address", int'(address), 0);
        do_clear();

        enter4(1, 2, 3, 5);
        check("t2_error", int'(error_light), 1);
        check("t2_tries", int'(tries_left), 2);
        do_clear();
        cyc(0, 0, 0, 0, 1);
        check("t2_rl_tries", int'(tries_left), 3);
        enter4(1, 2, 3, 5);
        do_clear();
        enter4(1, 2, 3, 4);
        check("t2_unlock", int'(unlock_light), 1);
        check("t2_tries_back", int'(tries_left), 3);
        do_clear();

        for (int k = 0; k < 3; k++) begin
            enter4(5, 5, 5, 5);
            if (k < 2) do_clear();
        end
        check("t3_lockdown", int'(lockdown), 1);
        check("t3_tries", int'(tries_left), 0);
        do_clear();
        enter4(1, 2, 3, 4);
        check("t3_still_locked", int'(lockdown), 1);
        enter4(9, 9, 9, 9);
        check("t3_admin_unlock", int'(unlock_light), 1);
        check("t3_admin", int'(admin), 1);
        check("t3_lock_off", int'(lockdown), 0);

        cyc(0, 0, 0, 1, 0);
        check("t4_programming", int'(programming), 1);
        enter4(7, 0, 7, 0);
        check("t4_prog_done", int'(programming), 0);
        do_clear();
        check("t4_relocked", int'(unlock_light), 0);
        enter4(1, 2, 3, 4);
        check("t4_old_fails", int'(error_light), 1);
        do_clear();
        enter4(7, 0, 7, 0);
        check("t4_new_unlock", int'(unlock_light), 1);

        @(negedge CLK);
        #1;
        chk = 0;
        RST = 0;
        model_reset();
        #2;
        check("t4_async_rst", int'(unlock_light), 0);
        @(posedge CLK);
        #2;
        RST = 1;
        chk = 1;
        enter4(1, 2, 3, 4);
        check("t4_default_back", int'(unlock_light), 1);

        cyc(0, 0, 0, 1, 0);
        cyc(1, 8, 0, 0, 0);
        cyc(1, 8, 0, 0, 0);
        check("t5_prog_addr", int'(address), 2);
        do_clear();
        check("t5_abort_unlocked", int'(unlock_light), 1);
        check("t5_abort_prog", int'(programming), 0);
        do_clear();
        enter4(1, 2, 3, 4);
        check("t5_pw_kept", int'(unlock_light), 1);
        do_clear();

        for (int k = 0; k < 3; k++) begin
            enter4(5, 5, 5, 5);
            do_clear();
        end
        check("t6_locked", int'(lockdown), 1);
        cyc(0, 0, 1, 0, 1);
        check("t6_unlocked_lock", int'(lockdown), 0);
        check("t6_tries", int'(tries_left), 3);
        check("t6_error", int'(error_light), 0);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 2, 0, 0, 0);
        cyc(1, 3, 0, 0, 0);
        check("t6_partial_addr", int'(address), 3);
        do_clear();
        check("t6_clear_addr", int'(address), 0);
        enter4(1, 2, 3, 4);
        check("t6_unlock", int'(unlock_light), 1);
        cyc(0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
